// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM bank: register map, duty array type and full-scale helper.
// PWM_SYNC_UPDATE_EN (see pwm_bank) selects period-synchronous duty updates.
package pwm_pkg;

  localparam int unsigned ADDR_OUT_EN = 0;
  localparam int unsigned ADDR_MODE   = 1;
  localparam int unsigned ADDR_PRESC  = 2;
  localparam int unsigned ADDR_DUTY0  = 3;

  localparam int unsigned DEF_NUM_CH = 8;
  localparam int unsigned DEF_CNT_W  = 8;

  typedef logic [DEF_CNT_W-1:0] duty_t;
  typedef duty_t duty_arr_t [DEF_NUM_CH];

  // Full-scale duty value; the counter period is this many steps.
  function automatic longint unsigned duty_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, period counter, step/wrap strobes and registered period tick.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] presc,
  output logic [CNT_W-1:0]   cnt,
  output logic               wrap,
  output logic               period_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(duty_max(CNT_W) - 64'd1);

  logic [PRESC_W-1:0] presc_cnt;
  logic               step;

  assign step = (presc_cnt == presc);
  assign wrap = step && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt   <= '0;
      cnt         <= '0;
      period_tick <= 1'b0;
    end else begin
      // A shrunk prescale value leaves presc_cnt above it; fold back to 0 without stepping.
      presc_cnt <= (presc_cnt >= presc) ? '0 : presc_cnt + 1'b1;
      if (step) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
      end
      period_tick <= wrap;
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank sharing one prescaled timebase, configured through a register write port.
// Define PWM_SYNC_UPDATE_EN to shadow duty registers and apply new duties only at period wrap.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PRESC_W = 4,
  parameter int unsigned ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(duty_max(CNT_W));

  logic [NUM_CH-1:0]  out_en;
  logic [NUM_CH-1:0]  pwm_mode;
  logic [PRESC_W-1:0] presc;
  logic [CNT_W-1:0]   duty     [NUM_CH];
  logic [CNT_W-1:0]   duty_act [NUM_CH];
  logic [NUM_CH-1:0]  duty_wr;
  logic [NUM_CH-1:0]  pwm_next;
  logic [CNT_W-1:0]   cnt;
  logic               wrap;

  pwm_timebase #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk         (clk),
    .rst         (rst),
    .presc       (presc),
    .cnt         (cnt),
    .wrap        (wrap),
    .period_tick (period_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_en   <= '0;
      pwm_mode <= '0;
      presc    <= '0;
    end else if (wr_en) begin
      if (wr_addr == ADDR_W'(ADDR_OUT_EN)) out_en   <= wr_data[NUM_CH-1:0];
      if (wr_addr == ADDR_W'(ADDR_MODE))   pwm_mode <= wr_data[NUM_CH-1:0];
      if (wr_addr == ADDR_W'(ADDR_PRESC))  presc    <= wr_data[PRESC_W-1:0];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign duty_wr[g] = wr_en && (wr_addr == ADDR_W'(ADDR_DUTY0 + g));

    always_ff @(posedge clk) begin
      if (rst) begin
        duty[g] <= '0;
      end else if (duty_wr[g]) begin
        duty[g] <= wr_data;
      end
    end

`ifdef PWM_SYNC_UPDATE_EN
    // A write landing on the wrap edge is forwarded so the new period uses it.
    always_ff @(posedge clk) begin
      if (rst) begin
        duty_act[g] <= '0;
      end else if (wrap) begin
        duty_act[g] <= duty_wr[g] ? wr_data : duty[g];
      end
    end
`else
    assign duty_act[g] = duty[g];
`endif

    assign pwm_next[g] = out_en[g] &&
                         (!pwm_mode[g] || (duty_act[g] == MAX) || (cnt < duty_act[g]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= pwm_next;
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: period-level measurements compared with an arithmetic model.
// Honours PWM_SYNC_UPDATE_EN when the design is built with it.
module tb_pwm_bank;
  import pwm_pkg::*;

  localparam int unsigned NCH   = 8;
  localparam int          STEPS = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] pwm_out;
  logic       period_tick;

  int total = 0;
  int bad   = 0;

  int        high_cnt [NCH];
  int        spacing;
  duty_arr_t m_duty;
  logic [7:0] m_en;
  logic [7:0] m_mode;
  int         m_presc;

  always #5 clk = ~clk;

  pwm_bank #(
    .NUM_CH  (8),
    .CNT_W   (8),
    .PRESC_W (4),
    .ADDR_W  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_en = '0;
    m_mode = '0;
    m_presc = 0;
    for (int i = 0; i < NCH; i++) m_duty[i] = '0;
  endfunction

  // Expected high cycles for channel i over one full period.
  function automatic int exp_high(input int i);
    int p;
    p = STEPS * (m_presc + 1);
    if (!m_en[i]) return 0;
    if (!m_mode[i]) return p;
    return int'(m_duty[i]) * (m_presc + 1);
  endfunction

  // Called at a negedge; the write takes place on the following posedge.
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a == 4'd0) m_en = d;
    else if (a == 4'd1) m_mode = d;
    else if (a == 4'd2) m_presc = int'(d[3:0]);
    else if (a >= 4'd3 && a < 4'd11) m_duty[int'(a) - 3] = d;
  endtask

  task automatic wait_tick(input int bound, input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_tick !== 1'b1 && n < bound);
    if (period_tick !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s: no period_tick within %0d cycles", name, bound);
    end
  endtask

  task automatic measure(input string name);
    int n;
    wait_tick(3000, name, n);
    spacing = 0;
    for (int i = 0; i < NCH; i++) high_cnt[i] = 0;
    do begin
      @(negedge clk);
      spacing++;
      for (int i = 0; i < NCH; i++) high_cnt[i] += int'(pwm_out[i]);
    end while (period_tick !== 1'b1 && spacing < 3000);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr(4'd1, 8'($urandom));
    wr(4'd2, 8'($urandom_range(1, 15)));
    for (int i = 0; i < NCH; i++) wr(4'(3 + i), 8'($urandom));
    wr(4'd0, 8'($urandom) | 8'h01);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (pwm_out !== 8'h00 || period_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: pwm_out=%h tick=%b, need 00/0", pwm_out, period_tick);
    end
    rst = 1'b0;
    model_reset();
    wait_tick(600, "reset_first_tick", n);
    total++;
    if (n != STEPS) begin
      bad++;
      $display("FAIL reset_first_tick: tick after %0d cycles, need %0d", n, STEPS);
    end
    total++;
    if (pwm_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_regs: pwm_out=%h, need 00", pwm_out);
    end
  endtask

  task automatic test_static();
    wr(4'd0, 8'h0F);
    @(negedge clk);
    total++;
    if (pwm_out !== 8'h0F) begin
      bad++;
      $display("FAIL static_on: pwm_out=%h, need 0f", pwm_out);
    end
    repeat (300) @(negedge clk);
    total++;
    if (pwm_out !== 8'h0F) begin
      bad++;
      $display("FAIL static_hold: pwm_out=%h, need 0f", pwm_out);
    end
  endtask

  task automatic test_duty();
    wr(4'd1, 8'hFF);
    wr(4'd2, 8'h00);
    wr(4'd3, 8'h80);
    wr(4'd4, 8'h00);
    wr(4'd5, 8'hFF);
    for (int i = 3; i < NCH; i++) wr(4'(3 + i), 8'($urandom));
    wr(4'd0, 8'hFF);
    measure("duty");
    total++;
    if (spacing != STEPS) begin
      bad++;
      $display("FAIL duty_period: spacing=%0d, need %0d", spacing, STEPS);
    end
    for (int i = 0; i < NCH; i++) begin
      total++;
      if (high_cnt[i] != exp_high(i)) begin
        bad++;
        $display("FAIL duty_ch%0d: high=%0d, need %0d", i, high_cnt[i], exp_high(i));
      end
    end
  endtask

  task automatic test_prescaler();
    wr(4'd2, 8'h03);
    measure("presc");
    total++;
    if (spacing != 1020) begin
      bad++;
      $display("FAIL presc_period: spacing=%0d, need 1020", spacing);
    end
    total++;
    if (high_cnt[0] != 512) begin
      bad++;
      $display("FAIL presc_ch0: high=%0d, need 512", high_cnt[0]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      wr(4'd2, 8'($urandom_range(0, 2)));
      wr(4'd1, 8'($urandom));
      for (int i = 0; i < NCH; i++) begin
        case ($urandom_range(0, 3))
          0: wr(4'(3 + i), 8'h00);
          1: wr(4'(3 + i), 8'hFF);
          default: wr(4'(3 + i), 8'($urandom));
        endcase
      end
      wr(4'd0, 8'($urandom));
      measure("random");
      total++;
      if (spacing != STEPS * (m_presc + 1)) begin
        bad++;
        $display("FAIL rand_period: it=%0d spacing=%0d, need %0d", it, spacing, STEPS * (m_presc + 1));
      end
      for (int i = 0; i < NCH; i++) begin
        total++;
        if (high_cnt[i] != exp_high(i)) begin
          bad++;
          $display("FAIL rand_ch%0d: it=%0d high=%0d, need %0d", i, it, high_cnt[i], exp_high(i));
        end
      end
    end
  endtask

  task automatic test_sync_update();
    int n;
    int h;
    int exp_first;
    wr(4'd0, 8'hFF);
    wr(4'd1, 8'hFF);
    wr(4'd2, 8'h00);
    wr(4'd3, 8'h80);
    wait_tick(3000, "sync_align", n);
    wait_tick(600, "sync_align2", n);
    h = 0;
    n = 0;
    repeat (8'h40) begin
      @(negedge clk);
      h += int'(pwm_out[0]);
      n++;
    end
    wr(4'd3, 8'h10);
    h += int'(pwm_out[0]);
    n++;
    while (period_tick !== 1'b1 && n < 600) begin
      @(negedge clk);
      h += int'(pwm_out[0]);
      n++;
    end
`ifdef PWM_SYNC_UPDATE_EN
    exp_first = 128;
`else
    exp_first = 65;
`endif
    total++;
    if (h != exp_first) begin
      bad++;
      $display("FAIL sync_current: high=%0d, need %0d", h, exp_first);
    end
    measure("sync_next");
    total++;
    if (high_cnt[0] != 16) begin
      bad++;
      $display("FAIL sync_next: high=%0d, need 16", high_cnt[0]);
    end
  endtask

  task automatic test_boundary();
    int n;
    int h;
    logic [7:0] nd;
    nd = 8'($urandom_range(1, 254));
    wait_tick(600, "wrap_align", n);
    repeat (254) @(negedge clk);
    wr(4'd3, nd);
    total++;
    if (period_tick !== 1'b1) begin
      bad++;
      $display("FAIL wrap_tick: tick=%b, need 1", period_tick);
    end
    h = 0;
    repeat (STEPS) begin
      @(negedge clk);
      h += int'(pwm_out[0]);
    end
    total++;
    if (h != int'(nd)) begin
      bad++;
      $display("FAIL wrap_write: high=%0d, need %0d", h, nd);
    end
    wr(4'd11, 8'($urandom));
    wr(4'd15, 8'($urandom));
    measure("unmapped");
    total++;
    if (spacing != STEPS) begin
      bad++;
      $display("FAIL unmapped_period: spacing=%0d, need %0d", spacing, STEPS);
    end
    for (int i = 0; i < NCH; i++) begin
      total++;
      if (high_cnt[i] != exp_high(i)) begin
        bad++;
        $display("FAIL unmapped_ch%0d: high=%0d, need %0d", i, high_cnt[i], exp_high(i));
      end
    end
    wr(4'd5, 8'hFF);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (pwm_out !== 8'h00 || period_tick !== 1'b0) begin
      bad++;
      $display("FAIL midrst_outputs: pwm_out=%h tick=%b, need 00/0", pwm_out, period_tick);
    end
    rst = 1'b0;
    model_reset();
    wait_tick(600, "midrst_tick", n);
    total++;
    if (n != STEPS || pwm_out !== 8'h00) begin
      bad++;
      $display("FAIL midrst_restart: tick after %0d pwm_out=%h, need %0d/00", n, pwm_out, STEPS);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_static();
    test_duty();
    test_prescaler();
    test_random();
    test_sync_update();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
